// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer: main road rests green, side-road car and
// pedestrian requests are latched and served in turn. All durations are counted
// in ticks, one tick per rising edge of the pulso_i strobe.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   pulso_i        tick strobe, synchronous to clk_i, any length
//   side_sensor_i  side-road vehicle present (level)
//   ped_btn_i      pedestrian request (level)
//   main_light_o   main-road lamps {red,yellow,green}, one-hot
//   side_light_o   side-road lamps {red,yellow,green}, one-hot
//   walk_o         pedestrian WALK lamp
//   ped_ack_o      one-cycle pulse when a pedestrian request is latched
//   state_o        current FSM state (debug)
module intersection_ctrl #(
  parameter int unsigned T_MAIN_MIN = 6,
  parameter int unsigned T_SIDE     = 4,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned T_WALK     = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pulso_i,
  input  logic       side_sensor_i,
  input  logic       ped_btn_i,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       walk_o,
  output logic       ped_ack_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StMainGreen = 3'd0,
    StMainYel   = 3'd1,
    StAllRedA   = 3'd2,
    StSideGreen = 3'd3,
    StSideYel   = 3'd4,
    StAllRedB   = 3'd5,
    StPedWalk   = 3'd6
  } state_e;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  // Timers count down from T_x-1 so a state lasts exactly T_x ticks.
  localparam logic [CNT_W-1:0] LdMain   = CNT_W'(T_MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] LdSide   = CNT_W'(T_SIDE - 1);
  localparam logic [CNT_W-1:0] LdYel    = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] LdAllRed = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LdWalk   = CNT_W'(T_WALK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pulso_q;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic [2:0]       main_q, main_d;
  logic [2:0]       side_q, side_d;
  logic             walk_q, walk_d;

  logic             tick;
  logic             expired;
  logic             enter_side;
  logic             enter_walk;
  logic [CNT_W-1:0] load_val;

  assign tick    = pulso_i & ~pulso_q;
  assign expired = tick & (timer_q == '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StAllRedB;
      timer_q     <= LdAllRed;
      pulso_q     <= 1'b0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
      main_q      <= LampRed;
      side_q      <= LampRed;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulso_q     <= pulso_i;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_q      <= walk_d;
    end
  end

  // Next-state, timer and request latches
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StMainGreen: if (expired && (side_pend_q || ped_pend_q)) state_d = StMainYel;
      StMainYel:   if (expired) state_d = StAllRedA;
      StAllRedA:   if (expired) state_d = side_pend_q ? StSideGreen : StPedWalk;
      StSideGreen: if (expired) state_d = StSideYel;
      StSideYel:   if (expired) state_d = StAllRedB;
      StAllRedB:   if (expired) state_d = ped_pend_q ? StPedWalk : StMainGreen;
      StPedWalk:   if (expired) state_d = StAllRedB;
      default:     state_d = StAllRedB; // unused encoding recovers at once
    endcase

    load_val = LdAllRed;
    unique case (state_d)
      StMainGreen: load_val = LdMain;
      StMainYel:   load_val = LdYel;
      StSideGreen: load_val = LdSide;
      StSideYel:   load_val = LdYel;
      StPedWalk:   load_val = LdWalk;
      default:     load_val = LdAllRed;
    endcase

    // An expired main green with nothing pending simply holds at zero.
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = load_val;
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    enter_side = (state_d == StSideGreen) && (state_q != StSideGreen);
    enter_walk = (state_d == StPedWalk) && (state_q != StPedWalk);

    // Clearing on service entry takes priority over a same-cycle request.
    side_pend_d = side_pend_q;
    if (enter_side) begin
      side_pend_d = 1'b0;
    end else if (side_sensor_i) begin
      side_pend_d = 1'b1;
    end

    ped_pend_d = ped_pend_q;
    if (enter_walk) begin
      ped_pend_d = 1'b0;
    end else if (ped_btn_i && (state_q != StPedWalk)) begin
      ped_pend_d = 1'b1;
    end

    ped_ack_d = ped_pend_d & ~ped_pend_q;
  end

  // Outputs decoded from the next state so they change on the same edge.
  always_comb begin
    main_d = LampRed;
    side_d = LampRed;
    walk_d = 1'b0;
    unique case (state_d)
      StMainGreen: main_d = LampGrn;
      StMainYel:   main_d = LampYel;
      StSideGreen: side_d = LampGrn;
      StSideYel:   side_d = LampYel;
      StPedWalk:   walk_d = 1'b1;
      default:     ;
    endcase
  end

  assign main_light_o = main_q;
  assign side_light_o = side_q;
  assign walk_o       = walk_q;
  assign ped_ack_o    = ped_ack_q;
  assign state_o      = state_q;

endmodule
